// File: rtl/joy_serial_reader.sv
// Joystick adapter front end: drives JOY_CLK/JOY_LOAD, samples the 24-bit serial frame into
// shadows and commits both players at once. Define JOY_DEBOUNCE_EN for two-frame agreement.
module joy_serial_reader #(
    parameter int unsigned CLK_DIV_LOG2 = 4
) (
    input  logic        clk12,
    input  logic        RESET_L,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_done
);

    localparam logic [4:0]              LastSlot = 5'd25;
    localparam logic [CLK_DIV_LOG2-1:0] DivOne   = 1;

    logic [CLK_DIV_LOG2-1:0] div_q;
    logic                    joy_clk_q;
    logic                    joy_load_q;
    logic                    frame_done_q;
    logic [4:0]              slot_q, slot_d;
    // Shadow and output words are packed as {player 2, player 1}.
    logic [23:0]             sh_q, sh_d;
    logic [23:0]             joy_q, joy_d;
    logic                    rise;
    logic                    commit;
    logic [4:0]              bit_idx;
    logic                    bit_vld;

    assign rise   = (&div_q) & ~joy_clk_q;
    assign commit = rise && (slot_q == LastSlot);
    assign slot_d = (slot_q == LastSlot) ? 5'd0 : slot_q + 5'd1;

    // Adapter bit order: slot -> packed shadow bit.
    always_comb begin
        bit_idx = 5'd0;
        bit_vld = 1'b1;
        case (slot_q)
            5'd2:    bit_idx = 5'd8;
            5'd3:    bit_idx = 5'd6;
            5'd4:    bit_idx = 5'd5;
            5'd5:    bit_idx = 5'd4;
            5'd6:    bit_idx = 5'd3;
            5'd7:    bit_idx = 5'd2;
            5'd8:    bit_idx = 5'd1;
            5'd9:    bit_idx = 5'd0;
            5'd10:   bit_idx = 5'd20;
            5'd11:   bit_idx = 5'd18;
            5'd12:   bit_idx = 5'd17;
            5'd13:   bit_idx = 5'd16;
            5'd14:   bit_idx = 5'd15;
            5'd15:   bit_idx = 5'd14;
            5'd16:   bit_idx = 5'd13;
            5'd17:   bit_idx = 5'd12;
            5'd18:   bit_idx = 5'd22;
            5'd19:   bit_idx = 5'd23;
            5'd20:   bit_idx = 5'd21;
            5'd21:   bit_idx = 5'd19;
            5'd22:   bit_idx = 5'd10;
            5'd23:   bit_idx = 5'd11;
            5'd24:   bit_idx = 5'd9;
            5'd25:   bit_idx = 5'd7;
            default: bit_vld = 1'b0;
        endcase
    end

    // sh_d already contains the slot-25 bit, so it is the complete frame at commit.
    always_comb begin
        sh_d = sh_q;
        if (rise && bit_vld) begin
            sh_d[bit_idx] = JOY_DATA;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [23:0] prev_q;
    logic [23:0] differ;

    always_ff @(posedge clk12 or negedge RESET_L) begin
        if (!RESET_L) begin
            prev_q <= '1;
        end else if (commit) begin
            prev_q <= sh_d;
        end
    end

    assign differ = sh_d ^ prev_q;
    assign joy_d  = (sh_d & ~differ) | (joy_q & differ);
`else
    assign joy_d = sh_d;
`endif

    always_ff @(posedge clk12 or negedge RESET_L) begin
        if (!RESET_L) begin
            div_q        <= '0;
            joy_clk_q    <= 1'b0;
            slot_q       <= 5'd0;
            joy_load_q   <= 1'b0;
            sh_q         <= '1;
            joy_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_q + DivOne;
            frame_done_q <= commit;
            sh_q         <= sh_d;
            if (&div_q) begin
                joy_clk_q <= ~joy_clk_q;
            end
            if (rise) begin
                slot_q     <= slot_d;
                joy_load_q <= (slot_d != 5'd0);
            end
            if (commit) begin
                joy_q <= joy_d;
            end
        end
    end

    assign JOY_CLK    = joy_clk_q;
    assign JOY_LOAD   = joy_load_q;
    assign joystick1  = joy_q[11:0];
    assign joystick2  = joy_q[23:12];
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: cycle-level model derived from edge counts since reset release,
// randomized serial frames with garbage between sample points, plus literal spot checks.
module tb_joy_serial_reader;

    localparam int unsigned DIV   = 4;
    localparam int          H     = 1 << DIV;
    localparam int          FRAME = 26 * 2 * H;

    logic        clk12    = 1'b0;
    logic        RESET_L  = 1'b0;
    logic        JOY_DATA = 1'b1;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        frame_done;
    logic [11:0] joystick1;
    logic [11:0] joystick2;

    int          checks = 0;
    int          errors = 0;
    int          k      = 0;
    bit          in_reset = 1'b1;
    logic        exp_clk  = 1'b0;
    logic        exp_load = 1'b0;
    logic        exp_fd   = 1'b0;
    logic [11:0] exp_j1   = 12'hFFF;
    logic [11:0] exp_j2   = 12'hFFF;
    logic [23:0] prev24   = '1;
    logic        frame_bits [26];
    int          map_idx [26];
    logic [25:0] cur_pat  = '1;

    joy_serial_reader #(.CLK_DIV_LOG2(DIV)) dut (
        .clk12      (clk12),
        .RESET_L    (RESET_L),
        .JOY_DATA   (JOY_DATA),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done)
    );

    always #5 clk12 = ~clk12;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("JOY_CLK", 32'(JOY_CLK), 32'(exp_clk));
        check("JOY_LOAD", 32'(JOY_LOAD), 32'(exp_load));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("joystick1", 32'(joystick1), 32'(exp_j1));
        check("joystick2", 32'(joystick2), 32'(exp_j2));
    endtask

    task automatic model_commit();
        logic [23:0] nw;
        logic [23:0] cur;
        nw  = '1;
        for (int s = 2; s < 26; s++) nw[map_idx[s]] = frame_bits[s];
        cur = {exp_j2, exp_j1};
`ifdef JOY_DEBOUNCE_EN
        for (int i = 0; i < 24; i++) if (nw[i] == prev24[i]) cur[i] = nw[i];
        prev24 = nw;
`else
        cur = nw;
`endif
        exp_j1 = cur[11:0];
        exp_j2 = cur[23:12];
    endtask

    // Edge k after release: JOY_CLK = bit DIV of k; rises at k = H + 2H*m sample slot m mod 26.
    task automatic model_edge(input logic d);
        int r;
        int s;
        k++;
        exp_clk  = ((k / H) % 2) == 1;
        r        = (k >= H) ? (k - H) / (2 * H) + 1 : 0;
        exp_load = (r % 26) != 0;
        exp_fd   = 1'b0;
        if (k >= H && (k - H) % (2 * H) == 0) begin
            s = ((k - H) / (2 * H)) % 26;
            frame_bits[s] = d;
            if (s == 25) begin
                model_commit();
                exp_fd = 1'b1;
            end
        end
    endtask

    task automatic step();
        int   kn;
        int   s;
        logic d;
        kn = k + 1;
        if (kn >= H && (kn - H) % (2 * H) == 0) begin
            s = ((kn - H) / (2 * H)) % 26;
            d = cur_pat[s];
        end else begin
            d = 1'($urandom_range(0, 1));
        end
        JOY_DATA = d;
        @(posedge clk12);
        if (!in_reset) model_edge(d);
        @(negedge clk12);
        compare_all();
    endtask

    task automatic run_frame(input logic [25:0] pat, input int exp_len);
        int n;
        cur_pat = pat;
        n = 0;
        do begin
            step();
            n++;
        end while (!exp_fd && n < 2 * FRAME);
        if (!exp_fd) begin
            errors++;
            $display("FAIL frame_timeout at t=%0t: got no commit expected one within %0d", $time,
                     2 * FRAME);
        end
        check("frame_len", 32'(n), 32'(exp_len));
    endtask

    task automatic run_until_slot(input logic [25:0] pat, input int stop_slot);
        cur_pat = pat;
        for (int n = 0; n < FRAME; n++) begin
            step();
            if (k >= H && (k - H) % (2 * H) == 0 && ((k - H) / (2 * H)) % 26 == stop_slot - 1)
                break;
        end
    endtask

    task automatic do_reset();
        #2 RESET_L = 1'b0;
        #1;
        check("rst_joystick1", 32'(joystick1), 32'h0FFF);
        check("rst_joystick2", 32'(joystick2), 32'h0FFF);
        check("rst_JOY_LOAD", 32'(JOY_LOAD), 32'h0);
        check("rst_JOY_CLK", 32'(JOY_CLK), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        in_reset = 1'b1;
        k        = 0;
        exp_clk  = 1'b0;
        exp_load = 1'b0;
        exp_fd   = 1'b0;
        exp_j1   = 12'hFFF;
        exp_j2   = 12'hFFF;
        prev24   = '1;
        for (int s = 0; s < 26; s++) frame_bits[s] = 1'b1;
        repeat (3) begin
            @(posedge clk12);
            @(negedge clk12);
            compare_all();
        end
        RESET_L  = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        logic [25:0] p;
        logic [23:0] w;
        map_idx = '{-1, -1, 8, 6, 5, 4, 3, 2, 1, 0, 20, 18, 17, 16, 15, 14, 13, 12,
                    22, 23, 21, 19, 10, 11, 9, 7};

        @(negedge clk12);
        do_reset();

        // Idle adapter: first commit lands 16 + 25*32 edges after release.
        run_frame('1, 816);
        check("idle_j1", 32'(joystick1), 32'h0FFF);
        run_frame('1, 832);
        run_frame('1, 832);
        check("idle_j2", 32'(joystick2), 32'h0FFF);

        p = ~(26'd1 << 5);
        run_frame(p, FRAME);
        run_frame(p, FRAME);
        check("slot5_j1", 32'(joystick1), 32'h0FEF);
        check("slot5_j2", 32'(joystick2), 32'h0FFF);

        p = ~((26'd1 << 19) | (26'd1 << 23));
        run_frame(p, FRAME);
        run_frame(p, FRAME);
        check("slot19_23_j1", 32'(joystick1), 32'h07FF);
        check("slot19_23_j2", 32'(joystick2), 32'h07FF);

        p = ~26'd3;
        run_frame(p, FRAME);
        run_frame(p, FRAME);
        check("slot01_j1", 32'(joystick1), 32'h0FFF);
        check("slot01_j2", 32'(joystick2), 32'h0FFF);

        for (int s = 2; s < 26; s++) begin
            p = ~(26'd1 << s);
            run_frame(p, FRAME);
            run_frame(p, FRAME);
            w = '1;
            w[map_idx[s]] = 1'b0;
            check("map_j1", 32'(joystick1), 32'(w[11:0]));
            check("map_j2", 32'(joystick2), 32'(w[23:12]));
        end

        // Single-frame glitch on slot 9, then a held press.
        run_frame('1, FRAME);
        p = ~(26'd1 << 9);
        run_frame(p, FRAME);
`ifdef JOY_DEBOUNCE_EN
        check("glitch9_j1", 32'(joystick1), 32'h0FFF);
`else
        check("glitch9_j1", 32'(joystick1), 32'h0FFE);
`endif
        run_frame('1, FRAME);
        run_frame(p, FRAME);
        run_frame(p, FRAME);
        check("press9_j1", 32'(joystick1), 32'h0FFE);

        // Reset mid-frame with zeros already shifted into slots 2..13.
        run_until_slot(~26'h0003FFC, 14);
        do_reset();
        run_frame('1, 816);
        check("post_rst_j1", 32'(joystick1), 32'h0FFF);
        check("post_rst_j2", 32'(joystick2), 32'h0FFF);

        for (int i = 0; i < 12; i++) begin
            p = 26'($urandom | $urandom);
            run_frame(p, FRAME);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
